// File: rtl/exec_pkg.sv
// exec_pkg: shared enums, $ra index, FSM states and M-stage control struct for the execute stage
package exec_pkg;
  typedef enum logic [2:0] {MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO} md_op_e;
  typedef enum logic [1:0] {HS_ALU, HS_HI, HS_LO} hilo_sel_e;
  typedef enum logic [1:0] {FWD_RF, FWD_W, FWD_M, FWD_RSV} fwd_sel_e;
  typedef enum logic [3:0] {
    ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SUB, ALU_SLT,
    ALU_SRL, ALU_SRA, ALU_SLTU, ALU_LUI
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} md_state_e;
  localparam logic [31:0] RA_REG = '1;
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
  } m_ctrl_t;
endpackage

// File: rtl/execute_md_mul_div_unit.sv
// mul_div_unit: iterative multiply / restoring divide FSM owning HI/LO (start,op,a,b -> busy,hi,lo)
module mul_div_unit import exec_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  md_op_e            op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int CW = $clog2((MUL_CYCLES > DATA_W ? MUL_CYCLES : DATA_W) + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DATA_W - 1);
  md_state_e r_state, w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [2*DATA_W-1:0] r_ma, r_mb, w_prod;
  logic [DATA_W-1:0] r_hi, r_lo, r_dvd, r_rem, r_quo, r_dsr;
  logic [DATA_W-1:0] w_abs_a, w_abs_b, w_rem_nx, w_quo_nx;
  logic [DATA_W:0] w_rem_sh, w_diff;
  logic r_neg_q, r_neg_r, w_sgn, w_last, w_borrow, w_go;
  assign w_go = start_i && r_state == S_IDLE;
  assign w_sgn = op_i == MD_MULT || op_i == MD_DIV;
  assign w_abs_a = (w_sgn && a_i[DATA_W-1]) ? -a_i : a_i;
  assign w_abs_b = (w_sgn && b_i[DATA_W-1]) ? -b_i : b_i;
  assign w_last = r_cnt == (r_state == S_MUL ? MUL_LAST : DIV_LAST);
  assign w_prod = r_ma * r_mb;
  assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
  assign w_diff = w_rem_sh - {1'b0, r_dsr};
  assign w_borrow = w_diff[DATA_W];
  assign w_rem_nx = w_borrow ? w_rem_sh[DATA_W-1:0] : w_diff[DATA_W-1:0];
  assign w_quo_nx = {r_quo[DATA_W-2:0], ~w_borrow};
  assign busy_o = r_state != S_IDLE;
  assign hi_o = r_hi;
  assign lo_o = r_lo;
  always_comb begin
    w_state_nx = r_state;
    if (w_go)
      w_state_nx = (op_i == MD_MULT || op_i == MD_MULTU) ? S_MUL :
                   (op_i == MD_DIV || op_i == MD_DIVU) ? S_DIV : S_IDLE;
    else if (r_state != S_IDLE && w_last)
      w_state_nx = S_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_ma <= '0;
      r_mb <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_dvd <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dsr <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_IDLE || w_last) ? '0 : r_cnt + 1'b1;
      if (w_go) begin
        r_ma <= w_sgn ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : {{DATA_W{1'b0}}, a_i};
        r_mb <= w_sgn ? {{DATA_W{b_i[DATA_W-1]}}, b_i} : {{DATA_W{1'b0}}, b_i};
        r_dvd <= a_i;
        r_quo <= w_abs_a;
        r_dsr <= w_abs_b;
        r_rem <= '0;
        r_neg_q <= w_sgn & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
        r_neg_r <= w_sgn & a_i[DATA_W-1];
        if (op_i == MD_MTHI) r_hi <= a_i;
        if (op_i == MD_MTLO) r_lo <= a_i;
      end
      if (r_state == S_DIV) begin
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
      end
      if (r_state == S_MUL && w_last) {r_hi, r_lo} <= w_prod;
      if (r_state == S_DIV && w_last) begin
        r_hi <= r_dsr == '0 ? r_dvd : r_neg_r ? -w_rem_nx : w_rem_nx;
        r_lo <= r_dsr == '0 ? '1 : r_neg_q ? -w_quo_nx : w_quo_nx;
      end
    end
  end
endmodule

// File: rtl/execute_md.sv
// execute_md: execute stage (forwarding, ALU, dest select, E->M register) with background mul/div and HI/LO
module execute_md import exec_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_e_i,
  input  logic                  flush_e_i,
  input  logic                  reg_write_e_i,
  input  logic                  mem_write_e_i,
  input  logic                  mem_to_reg_e_i,
  input  logic                  reg_dst_e_i,
  input  logic                  link_e_i,
  input  logic [1:0]            alu_src_e_i,
  input  logic [3:0]            alu_control_e_i,
  input  logic [2:0]            md_op_e_i,
  input  logic [1:0]            hilo_sel_e_i,
  input  logic [DATA_W-1:0]     reg_data_1_e_i,
  input  logic [DATA_W-1:0]     reg_data_2_e_i,
  input  logic [DATA_W-1:0]     sign_imm_e_i,
  input  logic [DATA_W-1:0]     result_w_i,
  input  logic [REG_ADDR_W-1:0] rt_e_i,
  input  logic [REG_ADDR_W-1:0] rd_e_i,
  input  logic [4:0]            shamt_e_i,
  input  logic [1:0]            forward_a_e_i,
  input  logic [1:0]            forward_b_e_i,
  output logic [REG_ADDR_W-1:0] write_reg_e_o,
  output logic                  stall_e_o,
  output logic                  md_busy_o,
  output logic                  reg_write_m_o,
  output logic                  mem_write_m_o,
  output logic                  mem_to_reg_m_o,
  output logic [DATA_W-1:0]     alu_out_m_o,
  output logic [DATA_W-1:0]     write_data_m_o,
  output logic [REG_ADDR_W-1:0] write_reg_m_o
);
  localparam int SW = $clog2(DATA_W);
  m_ctrl_t r_m_ctrl;
  logic [DATA_W-1:0] r_alu_out_m, r_wd_m;
  logic [REG_ADDR_W-1:0] r_wr_m;
  logic [DATA_W-1:0] w_fa, w_fb, w_a, w_b, w_alu, w_sra, w_res, w_hi, w_lo;
  logic [SW-1:0] w_sh;
  logic w_accept, w_busy;
  assign w_fa = forward_a_e_i == FWD_W ? result_w_i : forward_a_e_i == FWD_M ? r_alu_out_m : reg_data_1_e_i;
  assign w_fb = forward_b_e_i == FWD_W ? result_w_i : forward_b_e_i == FWD_M ? r_alu_out_m : reg_data_2_e_i;
  assign w_a = alu_src_e_i[1] ? {{(DATA_W-5){1'b0}}, shamt_e_i} : w_fa;
  assign w_b = alu_src_e_i[0] ? sign_imm_e_i : w_fb;
  assign w_sh = w_a[SW-1:0];
  assign w_sra = $signed(w_b) >>> w_sh;
  always_comb begin
    w_alu = '0;
    case (alu_control_e_i)
      ALU_AND:  w_alu = w_a & w_b;
      ALU_OR:   w_alu = w_a | w_b;
      ALU_ADD:  w_alu = w_a + w_b;
      ALU_XOR:  w_alu = w_a ^ w_b;
      ALU_NOR:  w_alu = ~(w_a | w_b);
      ALU_SLL:  w_alu = w_b << w_sh;
      ALU_SUB:  w_alu = w_a - w_b;
      ALU_SLT:  w_alu = {{(DATA_W-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      ALU_SRL:  w_alu = w_b >> w_sh;
      ALU_SRA:  w_alu = w_sra;
      ALU_SLTU: w_alu = {{(DATA_W-1){1'b0}}, w_a < w_b};
      ALU_LUI:  w_alu = w_b << (DATA_W / 2);
      default:  w_alu = '0;
    endcase
  end
  assign w_res = hilo_sel_e_i == HS_HI ? w_hi : hilo_sel_e_i == HS_LO ? w_lo : w_alu;
  assign write_reg_e_o = link_e_i ? RA_REG[REG_ADDR_W-1:0] : reg_dst_e_i ? rd_e_i : rt_e_i;
  assign stall_e_o = valid_e_i && !flush_e_i && w_busy && (hilo_sel_e_i != HS_ALU || md_op_e_i != MD_NONE);
  assign w_accept = valid_e_i && !flush_e_i && !stall_e_o;
  assign md_busy_o = w_busy;
  mul_div_unit #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) u_md (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(w_accept && md_op_e_i != MD_NONE),
    .op_i   (md_op_e'(md_op_e_i)),
    .a_i    (w_fa),
    .b_i    (w_fb),
    .busy_o (w_busy),
    .hi_o   (w_hi),
    .lo_o   (w_lo)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_accept) begin
      r_m_ctrl <= '0;
      r_alu_out_m <= '0;
      r_wd_m <= '0;
      r_wr_m <= '0;
    end else begin
      r_m_ctrl <= '{reg_write_e_i, mem_write_e_i, mem_to_reg_e_i};
      r_alu_out_m <= w_res;
      r_wd_m <= w_fb;
      r_wr_m <= write_reg_e_o;
    end
  end
  assign reg_write_m_o = r_m_ctrl.reg_write;
  assign mem_write_m_o = r_m_ctrl.mem_write;
  assign mem_to_reg_m_o = r_m_ctrl.mem_to_reg;
  assign alu_out_m_o = r_alu_out_m;
  assign write_data_m_o = r_wd_m;
  assign write_reg_m_o = r_wr_m;
endmodule
